lbist_resp_shbuf: RTL and testbench



---
 rtl/lbist_resp_shbuf.sv | 153 +++++++++++++++
 tb/tb_lbist_resp_shbuf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_resp_shbuf.sv
// LBIST response capture buffer: address-sequenced DEPTH-stage shift register with
// fill tracking, optional freeze-on-full and sticky sequence error. Optional macro: LBIST_RESP_DUP_CHK_EN.
module lbist_resp_shbuf #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 8,
    parameter int HOLD_FULL = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW-1:0]                addr,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_vld,
    output logic [WIDTH*DEPTH-1:0]       dout,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         full,
    output logic [AW-1:0]                expect_addr,
    output logic                         armed,
    output logic                         seq_err,
    output logic                         dup
);

    localparam int FW = $clog2(DEPTH+1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  stage_r [DEPTH];
    logic [FW-1:0]     fill_r;
    logic [FW-1:0]     fill_nxt_s;
    logic              full_r;
    logic [AW-1:0]     expect_r;
    logic              seq_err_r;
    logic              dup_r;
    logic              capture_s;
    logic              mismatch_s;
    logic              dup_hit_s;

`ifdef LBIST_RESP_DUP_CHK_EN
    // A repeated word on consecutive captures hints at a stuck CUT response.
    assign dup_hit_s = (din == stage_r[0]) && (fill_r != {FW{1'b0}});
`else
    assign dup_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and capture/mismatch decode; init overrides any word in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        mismatch_s  = 1'b0;
        fill_nxt_s  = fill_r;
        if (init) begin
            state_nxt_s = ST_ARMED;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (din_vld) begin
                        if (addr == expect_r) begin
                            capture_s = 1'b1;
                        end else begin
                            mismatch_s = 1'b1;
                        end
                    end else begin
                        capture_s = 1'b0;
                    end
                end
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_HALT:  state_nxt_s = ST_HALT;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
        if (capture_s) begin
            if (fill_r == FILL_MAX) begin
                fill_nxt_s = fill_r;
            end else begin
                fill_nxt_s = fill_r + FW'(1);
            end
            if ((HOLD_FULL != 0) && (fill_nxt_s == FILL_MAX)) begin
                state_nxt_s = ST_HALT;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Shift stages; the oldest word falls off the end when full and not frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage_r[k] <= {WIDTH{1'b0}};
        end else if (init) begin
            for (int k = 0; k < DEPTH; k++) stage_r[k] <= {WIDTH{1'b0}};
        end else if (capture_s) begin
            stage_r[0] <= din;
            for (int k = 1; k < DEPTH; k++) stage_r[k] <= stage_r[k-1];
        end else begin
            for (int k = 0; k < DEPTH; k++) stage_r[k] <= stage_r[k];
        end
    end

    // Fill, address tracking, sticky error and duplicate flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r    <= {FW{1'b0}};
            full_r    <= 1'b0;
            expect_r  <= {AW{1'b0}};
            seq_err_r <= 1'b0;
            dup_r     <= 1'b0;
        end else if (init) begin
            fill_r    <= {FW{1'b0}};
            full_r    <= 1'b0;
            expect_r  <= base_addr;
            seq_err_r <= 1'b0;
            dup_r     <= 1'b0;
        end else begin
            fill_r    <= fill_nxt_s;
            full_r    <= (fill_nxt_s == FILL_MAX);
            expect_r  <= capture_s ? (expect_r + AW'(1)) : expect_r;
            seq_err_r <= seq_err_r | mismatch_s;
            dup_r     <= capture_s & dup_hit_s;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_dout
        assign dout[g*WIDTH +: WIDTH] = stage_r[g];
    end

    assign fill        = fill_r;
    assign full        = full_r;
    assign expect_addr = expect_r;
    assign armed       = (state_r != ST_IDLE);
    assign seq_err     = seq_err_r;
    assign dup         = dup_r;

endmodule

// File: tb/tb_lbist_resp_shbuf.sv
// Scoreboard bench for lbist_resp_shbuf: one instance per HOLD_FULL setting, shared stimulus.
module tb_lbist_resp_shbuf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;

    logic [31:0] dout [2];
    logic [2:0]  fill [2];
    logic        full [2];
    logic [7:0]  expect_addr [2];
    logic        armed [2];
    logic        seq_err [2];
    logic        dup [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] dout;
        logic [2:0]  fill;
        logic        full;
        logic [7:0]  ea;
        logic        armed;
        logic        seq_err;
        logic        dup;
    } exp_t;

    exp_t sb_q [2][$];

    // Reference model state, index 0 = shifting, 1 = freeze-on-full.
    logic [7:0] m_stage [2][4];
    int         m_fill [2];
    logic [7:0] m_ea [2];
    int         m_st [2];   // 0 idle, 1 armed, 2 halt
    logic       m_seq [2];
    logic       m_dup [2];

`ifdef LBIST_RESP_DUP_CHK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    lbist_resp_shbuf #(.WIDTH(8), .DEPTH(4), .AW(8), .HOLD_FULL(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .init(init), .base_addr(base_addr), .addr(addr),
        .din(din), .din_vld(din_vld), .dout(dout[0]), .fill(fill[0]), .full(full[0]),
        .expect_addr(expect_addr[0]), .armed(armed[0]), .seq_err(seq_err[0]), .dup(dup[0])
    );

    lbist_resp_shbuf #(.WIDTH(8), .DEPTH(4), .AW(8), .HOLD_FULL(1)) u_dut_hold (
        .clk(clk), .rst_n(rst_n), .init(init), .base_addr(base_addr), .addr(addr),
        .din(din), .din_vld(din_vld), .dout(dout[1]), .fill(fill[1]), .full(full[1]),
        .expect_addr(expect_addr[1]), .armed(armed[1]), .seq_err(seq_err[1]), .dup(dup[1])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 4; k++) m_stage[h][k] = 8'h00;
            m_fill[h] = 0; m_ea[h] = 8'h00; m_st[h] = 0; m_seq[h] = 1'b0; m_dup[h] = 1'b0;
        end
    endtask

    task automatic model_step(input int h);
        logic d;
        if (init) begin
            for (int k = 0; k < 4; k++) m_stage[h][k] = 8'h00;
            m_fill[h] = 0; m_ea[h] = base_addr; m_seq[h] = 1'b0; m_dup[h] = 1'b0; m_st[h] = 1;
        end else if (m_st[h] == 1 && din_vld) begin
            if (addr == m_ea[h]) begin
                d = DUP_EN && (din == m_stage[h][0]) && (m_fill[h] != 0);
                for (int k = 3; k > 0; k--) m_stage[h][k] = m_stage[h][k-1];
                m_stage[h][0] = din;
                m_ea[h] = m_ea[h] + 8'h01;
                if (m_fill[h] < 4) m_fill[h]++;
                if (h == 1 && m_fill[h] == 4) m_st[h] = 2;
                m_dup[h] = d;
            end else begin
                m_seq[h] = 1'b1;
                m_dup[h] = 1'b0;
            end
        end else begin
            m_dup[h] = 1'b0;
        end
    endtask

    task automatic push_expect(input int h);
        exp_t e;
        for (int k = 0; k < 4; k++) e.dout[k*8 +: 8] = m_stage[h][k];
        e.fill = 3'(m_fill[h]);
        e.full = (m_fill[h] == 4);
        e.ea = m_ea[h];
        e.armed = (m_st[h] != 0);
        e.seq_err = m_seq[h];
        e.dup = m_dup[h];
        sb_q[h].push_back(e);
    endtask

    task automatic pop_compare(input int h);
        exp_t e;
        string p;
        p = (h == 0) ? "shift" : "hold";
        if (sb_q[h].size() == 0) begin
            check_val({p, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q[h].pop_front();
            check_val({p, "_dout"}, dout[h], e.dout);
            check_val({p, "_fill"}, 32'(fill[h]), 32'(e.fill));
            check_val({p, "_full"}, 32'(full[h]), 32'(e.full));
            check_val({p, "_expect_addr"}, 32'(expect_addr[h]), 32'(e.ea));
            check_val({p, "_armed"}, 32'(armed[h]), 32'(e.armed));
            check_val({p, "_seq_err"}, 32'(seq_err[h]), 32'(e.seq_err));
            check_val({p, "_dup"}, 32'(dup[h]), 32'(e.dup));
        end
    endtask

    task automatic drive(input logic i_init, input logic [7:0] i_base, input logic [7:0] i_addr,
                         input logic [7:0] i_din, input logic i_vld);
        init = i_init; base_addr = i_base; addr = i_addr; din = i_din; din_vld = i_vld;
        for (int h = 0; h < 2; h++) begin
            model_step(h);
            push_expect(h);
        end
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) pop_compare(h);
        init = 1'b0; din_vld = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int h = 0; h < 2; h++) begin
            check_val({tag, "_dout"}, dout[h], 32'd0);
            check_val({tag, "_fill"}, 32'(fill[h]), 32'd0);
            check_val({tag, "_flags"}, {27'd0, full[h], armed[h], seq_err[h], dup[h], 1'b0}, 32'd0);
            check_val({tag, "_expect_addr"}, 32'(expect_addr[h]), 32'd0);
        end
    endtask

    initial begin
        model_reset();
        #2;
        check_all_zero("reset");
        #10 rst_n = 1'b1;

        // No init yet: words ignored in IDLE.
        drive(1'b0, 8'h00, 8'h00, 8'hAA, 1'b1);

        // Arm at 0x10 and fill.
        drive(1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h10, 8'h11, 1'b1);
        drive(1'b0, 8'h00, 8'h11, 8'h22, 1'b1);
        drive(1'b0, 8'h00, 8'h12, 8'h33, 1'b1);
        drive(1'b0, 8'h00, 8'h13, 8'h44, 1'b1);
        check_val("fill_image_shift", dout[0], 32'h11223344);

        // Full: shifting instance drops oldest, hold instance is frozen.
        drive(1'b0, 8'h00, 8'h14, 8'h55, 1'b1);
        check_val("overflow_image_shift", dout[0], 32'h22334455);
        check_val("overflow_image_hold", dout[1], 32'h11223344);
        drive(1'b0, 8'h00, 8'h20, 8'h99, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Address wrap, then sequence error that stays sticky.
        drive(1'b1, 8'hFE, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'hFE, 8'hA1, 1'b1);
        drive(1'b0, 8'h00, 8'hFF, 8'hA2, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'hA3, 1'b1);
        drive(1'b0, 8'h00, 8'h05, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 8'h01, 8'hA4, 1'b1);
        drive(1'b0, 8'h00, 8'h02, 8'hA5, 1'b0);

        // init wins over a same-cycle word.
        drive(1'b1, 8'h30, 8'h30, 8'h77, 1'b1);
        drive(1'b0, 8'h00, 8'h30, 8'h78, 1'b1);
        drive(1'b0, 8'h00, 8'h31, 8'h79, 1'b1);

        // Asynchronous reset mid-fill, observed before the next edge.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #3 rst_n = 1'b1;

        // Duplicate detection across consecutive captures.
        drive(1'b1, 8'h40, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h40, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h41, 8'h5A, 1'b1);
        drive(1'b0, 8'h00, 8'h42, 8'h5A, 1'b1);
        check_val("dup_second_capture", 32'(dup[0]), 32'(DUP_EN));
        drive(1'b0, 8'h00, 8'h43, 8'h6B, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Random in-order and out-of-order traffic.
        drive(1'b1, 8'hC0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_ea[0];
            drive(1'b0, 8'h00, a, 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
